// File: rtl/kmeans_iter_ctrl.sv
// rtl/kmeans_iter_ctrl.sv - k-means iteration controller with label RAM and convergence detection
//
// Sequences repeated k-means passes: each pass pulses eng_start_o, accepts SAMPS
// labelled samples from the engine, stores them in a label RAM and counts how many
// labels differ from the previous pass. A run ends when a pass (other than the
// first) produces zero changes, when MAX_ITERS passes have completed, or on abort.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   go_i             start-run request, honoured only in IDLE
//   abort_i          terminate the current run at the next edge
//   eng_start_o      one-cycle start pulse per pass to the engine
//   eng_lbl_valid_i  engine presents one labelled sample
//   eng_addr_i       sample index of the presented label
//   eng_class_i      cluster label for eng_addr_i
//   busy_o           high whenever the controller is not IDLE
//   done_o           one-cycle pulse at the end of a run
//   converged_o      last run ended on a zero-change pass; held until next go_i
//   iters_o          passes completed in the current or last run
//   changes_o        label changes counted in the last completed pass
//   rd_addr_i        label RAM read address
//   rd_class_o       stored label at rd_addr_i, one cycle latency

module kmeans_iter_ctrl #(
    parameter int SAMPS     = 128,
    parameter int K         = 3,
    parameter int MAX_ITERS = 16,
    localparam int LW = (K > 1) ? $clog2(K) : 1,
    localparam int AW = (SAMPS > 1) ? $clog2(SAMPS) : 1,
    localparam int IW = $clog2(MAX_ITERS) + 1,
    localparam int CW = $clog2(SAMPS) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          go_i,
    input  logic          abort_i,
    output logic          eng_start_o,
    input  logic          eng_lbl_valid_i,
    input  logic [AW-1:0] eng_addr_i,
    input  logic [LW-1:0] eng_class_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          converged_o,
    output logic [IW-1:0] iters_o,
    output logic [CW-1:0] changes_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [LW-1:0] rd_class_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] LAST_LBL = CW'(SAMPS - 1);
    localparam logic [IW-1:0] MAX_IT   = IW'(MAX_ITERS);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] iters_q, iters_d;
    logic          conv_q, conv_d;
    logic [CW-1:0] changes_q, changes_d;
    logic [CW-1:0] lbl_cnt_q, lbl_cnt_d;
    logic [CW-1:0] chg_cnt_q, chg_cnt_d;
    logic [LW-1:0] rd_class_q;
    logic          wr_en;
    logic [LW-1:0] stored_lbl;

    // Label storage is deliberately not reset; contents are defined by the first pass.
    logic [LW-1:0] label_mem [SAMPS];

    // Asynchronous read of the label being overwritten, used for change detection.
    assign stored_lbl = label_mem[eng_addr_i];

    always_comb begin
        state_d   = state_q;
        iters_d   = iters_q;
        conv_d    = conv_q;
        changes_d = changes_q;
        lbl_cnt_d = lbl_cnt_q;
        chg_cnt_d = chg_cnt_q;
        wr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d   = S_START;
                    iters_d   = '0;
                    conv_d    = 1'b0;
                    lbl_cnt_d = '0;
                    chg_cnt_d = '0;
                end
            end
            S_START: begin
                lbl_cnt_d = '0;
                chg_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (eng_lbl_valid_i) begin
                    wr_en     = 1'b1;
                    lbl_cnt_d = lbl_cnt_q + CW'(1);
                    // On the first pass every label counts as a change: the RAM
                    // holds nothing meaningful to compare against.
                    if ((iters_q == '0) || (stored_lbl != eng_class_i)) begin
                        chg_cnt_d = chg_cnt_q + CW'(1);
                    end
                    // The pass ends on the label count alone, so repeated
                    // addresses still advance it.
                    if (lbl_cnt_q == LAST_LBL) begin
                        state_d = S_CHECK;
                        iters_d = iters_q + IW'(1);
                    end
                end
            end
            S_CHECK: begin
                changes_d = chg_cnt_q;
                if ((chg_cnt_q == '0) && (iters_q > IW'(1))) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (iters_q == MAX_IT) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above: no write, no counting, no pass credit.
        if (abort_i && ((state_q == S_START) || (state_q == S_RUN) || (state_q == S_CHECK))) begin
            state_d   = S_DONE;
            iters_d   = iters_q;
            conv_d    = 1'b0;
            changes_d = changes_q;
            lbl_cnt_d = lbl_cnt_q;
            chg_cnt_d = chg_cnt_q;
            wr_en     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            iters_q   <= '0;
            conv_q    <= 1'b0;
            changes_q <= '0;
            lbl_cnt_q <= '0;
            chg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iters_q   <= iters_d;
            conv_q    <= conv_d;
            changes_q <= changes_d;
            lbl_cnt_q <= lbl_cnt_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            label_mem[eng_addr_i] <= eng_class_i;
        end
    end

    // Registered read port; a same-cycle write to the same address returns the old label.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_class_q <= '0;
        end else begin
            rd_class_q <= label_mem[rd_addr_i];
        end
    end

    assign eng_start_o = (state_q == S_START);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign converged_o = conv_q;
    assign iters_o     = iters_q;
    assign changes_o   = changes_q;
    assign rd_class_o  = rd_class_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// tb/tb_kmeans_iter_ctrl.sv - self-checking bench for kmeans_iter_ctrl

module tb_kmeans_iter_ctrl;

    localparam int SAMPS = 128;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       go_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       eng_start_o;
    logic       eng_lbl_valid_i = 1'b0;
    logic [6:0] eng_addr_i = '0;
    logic [1:0] eng_class_i = '0;
    logic       busy_o;
    logic       done_o;
    logic       converged_o;
    logic [4:0] iters_o;
    logic [7:0] changes_o;
    logic [6:0] rd_addr_i = '0;
    logic [1:0] rd_class_o;

    kmeans_iter_ctrl #(.SAMPS(128), .K(3), .MAX_ITERS(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .go_i(go_i),
        .abort_i(abort_i),
        .eng_start_o(eng_start_o),
        .eng_lbl_valid_i(eng_lbl_valid_i),
        .eng_addr_i(eng_addr_i),
        .eng_class_i(eng_class_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .converged_o(converged_o),
        .iters_o(iters_o),
        .changes_o(changes_o),
        .rd_addr_i(rd_addr_i),
        .rd_class_o(rd_class_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_start_mon = 0;
    int n_done_mon = 0;

    always @(negedge clk_i) begin
        if (eng_start_o) n_start_mon++;
        if (done_o) n_done_mon++;
    end

    typedef struct {
        int kind;
        int exp_starts;
        int exp_iters;
        int exp_conv;
        int exp_chg;
        int exp_chg_first;
    } run_vec_t;

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    run_vec_t runs [4];
    rd_vec_t  rds  [6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // kind 0: fixed labels; 1: one new label altered per pass; 2: 5 labels
    // altered from pass 2 on; 3: fixed labels with address 5 forced to 1.
    function automatic logic [1:0] lab(input int kind, input int p, input int i);
        logic [1:0] base;
        logic [1:0] alt;
        base = 2'((i % 3));
        alt  = 2'(((i % 3) + 1) % 3);
        case (kind)
            1:       return (i < p - 1) ? alt : base;
            2:       return (p >= 2 && i < 5) ? alt : base;
            3:       return (i == 5) ? 2'd1 : base;
            default: return base;
        endcase
    endfunction

    // Returns 1 on eng_start_o, 2 on done_o, 0 on timeout.
    task automatic wait_evt(output int ev);
        ev = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (eng_start_o) begin ev = 1; return; end
            if (done_o) begin ev = 2; return; end
        end
        chk("event_timeout", 0, 1);
    endtask

    task automatic drive_pass(input int kind, input int p, input int n, input bit coll, input bit gop);
        @(posedge clk_i); #1;
        for (int i = 0; i < n; i++) begin
            eng_lbl_valid_i = 1'b1;
            eng_addr_i      = 7'(i);
            eng_class_i     = lab(kind, p, i);
            if (gop) go_i = (i == 10);
            @(posedge clk_i); #1;
            if (coll && p == 1 && i == 5) chk("collision_old", int'(rd_class_o), 1);
            if (coll && p == 1 && i == 6) chk("collision_new", int'(rd_class_o), 2);
        end
        eng_lbl_valid_i = 1'b0;
        go_i = 1'b0;
    endtask

    task automatic pulse_go();
        go_i = 1'b1;
        @(posedge clk_i); #1;
        go_i = 1'b0;
    endtask

    // Runs to completion; leaves the bench at the negedge where done_o is high.
    task automatic do_run(input int kind, input bit coll, output int starts, output int chg_first);
        int ev;
        int p;
        p = 0;
        starts = 0;
        chg_first = -1;
        if (coll) rd_addr_i = 7'd5;
        pulse_go();
        for (int g = 0; g < 40; g++) begin
            wait_evt(ev);
            if (ev != 1) break;
            starts++;
            p++;
            if (p == 2) chg_first = int'(changes_o);
            drive_pass(kind, p, SAMPS, coll, 1'b0);
        end
    endtask

    initial begin
        int starts;
        int chg_first;
        int d0;
        int s0;
        int ev;

        runs[0] = '{kind: 0, exp_starts: 2,  exp_iters: 2,  exp_conv: 1, exp_chg: 0, exp_chg_first: 128};
        runs[1] = '{kind: 2, exp_starts: 3,  exp_iters: 3,  exp_conv: 1, exp_chg: 0, exp_chg_first: 128};
        runs[2] = '{kind: 1, exp_starts: 16, exp_iters: 16, exp_conv: 0, exp_chg: 1, exp_chg_first: 128};
        runs[3] = '{kind: 3, exp_starts: 2,  exp_iters: 2,  exp_conv: 1, exp_chg: 0, exp_chg_first: 128};

        rds[0] = '{addr: 0,   exp: 0};
        rds[1] = '{addr: 5,   exp: 1};
        rds[2] = '{addr: 14,  exp: 2};
        rds[3] = '{addr: 127, exp: 1};
        rds[4] = '{addr: 16,  exp: 1};
        rds[5] = '{addr: 4,   exp: 1};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_start", int'(eng_start_o), 0);
        chk("rst_conv", int'(converged_o), 0);
        chk("rst_iters", int'(iters_o), 0);
        chk("rst_changes", int'(changes_o), 0);
        chk("rst_rd", int'(rd_class_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Table-driven full runs
        foreach (runs[r]) begin
            s0 = n_start_mon;
            d0 = n_done_mon;
            do_run(runs[r].kind, 1'b0, starts, chg_first);
            chk($sformatf("run%0d_done", r), int'(done_o), 1);
            chk($sformatf("run%0d_starts", r), starts, runs[r].exp_starts);
            chk($sformatf("run%0d_iters", r), int'(iters_o), runs[r].exp_iters);
            chk($sformatf("run%0d_conv", r), int'(converged_o), runs[r].exp_conv);
            chk($sformatf("run%0d_changes", r), int'(changes_o), runs[r].exp_chg);
            chk($sformatf("run%0d_chg_first", r), chg_first, runs[r].exp_chg_first);
            @(posedge clk_i); #1;
            chk($sformatf("run%0d_idle", r), int'(busy_o), 0);
            chk($sformatf("run%0d_done_pulses", r), n_done_mon - d0, 1);
            chk($sformatf("run%0d_start_pulses", r), n_start_mon - s0, runs[r].exp_starts);
        end

        // Label RAM read-back after the last table run
        foreach (rds[v]) begin
            rd_addr_i = 7'(rds[v].addr);
            @(posedge clk_i); #1;
            chk($sformatf("rd_addr%0d", rds[v].addr), int'(rd_class_o), rds[v].exp);
        end

        // Same-cycle read/write on address 5: old 1, new 2
        do_run(0, 1'b1, starts, chg_first);
        chk("coll_run_iters", int'(iters_o), 2);
        @(posedge clk_i); #1;

        // Abort in pass 3 with stray valid in CHECK and go in RUN
        s0 = n_start_mon;
        d0 = n_done_mon;
        pulse_go();
        wait_evt(ev);
        chk("ab_start1", ev, 1);
        drive_pass(1, 1, SAMPS, 1'b0, 1'b0);
        eng_lbl_valid_i = 1'b1;
        eng_addr_i      = 7'd3;
        eng_class_i     = 2'd2;
        @(posedge clk_i); #1;
        eng_lbl_valid_i = 1'b0;
        wait_evt(ev);
        chk("ab_start2", ev, 1);
        chk("ab_changes_p1", int'(changes_o), 128);
        drive_pass(1, 2, SAMPS, 1'b0, 1'b1);
        wait_evt(ev);
        chk("ab_start3", ev, 1);
        chk("ab_changes_p2", int'(changes_o), 1);
        drive_pass(1, 3, 50, 1'b0, 1'b0);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        chk("ab_done", int'(done_o), 1);
        chk("ab_iters", int'(iters_o), 2);
        chk("ab_conv", int'(converged_o), 0);
        @(posedge clk_i); #1;
        chk("ab_idle", int'(busy_o), 0);
        chk("ab_done_pulses", n_done_mon - d0, 1);
        chk("ab_start_pulses", n_start_mon - s0, 3);
        rd_addr_i = 7'd3;
        @(posedge clk_i); #1;
        chk("ab_check_nowrite", int'(rd_class_o), 0);

        // Stray label in IDLE: no write, no count change
        rd_addr_i       = 7'd7;
        eng_lbl_valid_i = 1'b1;
        eng_addr_i      = 7'd7;
        eng_class_i     = 2'd0;
        @(posedge clk_i); #1;
        eng_lbl_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_nowrite", int'(rd_class_o), 1);
        chk("idle_iters", int'(iters_o), 2);
        chk("idle_busy", int'(busy_o), 0);

        // Fresh run after abort
        do_run(0, 1'b0, starts, chg_first);
        chk("fresh_iters", int'(iters_o), 2);
        chk("fresh_conv", int'(converged_o), 1);
        chk("fresh_chg_first", chg_first, 128);
        @(posedge clk_i); #1;

        // Reset asserted mid-RUN in pass 2
        d0 = n_done_mon;
        rd_addr_i = 7'd1;
        pulse_go();
        wait_evt(ev);
        drive_pass(0, 1, SAMPS, 1'b0, 1'b0);
        wait_evt(ev);
        drive_pass(0, 2, 20, 1'b0, 1'b0);
        chk("pre_rst_iters", int'(iters_o), 1);
        chk("pre_rst_rd", int'(rd_class_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_iters", int'(iters_o), 0);
        chk("mid_rst_changes", int'(changes_o), 0);
        chk("mid_rst_conv", int'(converged_o), 0);
        chk("mid_rst_start", int'(eng_start_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_rd", int'(rd_class_o), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("mid_rst_no_done", n_done_mon - d0, 0);
        chk("mid_rst_idle", int'(busy_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
